cordic_sequencer: RTL and testbench

//   Controller in front of the single iterative CORDIC datapath. Arbitrates two angle requesters

---
 rtl/cordic_sequencer.sv | 149 ++++++++++++++
 tb/tb_cordic_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sequencer.sv
// -----------------------------------------------------------------------------
// cordic_sequencer
//
// Controller in front of a single iterative CORDIC datapath. Two angle
// requesters are arbitrated round-robin; the winning angle is handed to the
// datapath with a one-cycle load strobe, followed by ITERATIONS enable strobes
// carrying the micro-rotation index. The final X/Y are captured and returned
// with the owning requester ID over a valid/ready response port. Only one job
// is in flight at a time.
//
// Handshake semantics (both request ports and the response port):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. A producer holding valid keeps its payload stable until the transfer.
//   reqN_ready is combinational and can only be high while idle; rsp_valid is
//   registered and, once high, holds with stable rsp_id/rsp_x/rsp_y until the
//   edge on which rsp_ready is sampled high.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   req0_valid/angle/ready    requester 0 angle port
//   req1_valid/angle/ready    requester 1 angle port
//   dp_load, dp_angle         datapath load strobe and latched start angle
//   dp_en, dp_iter            datapath micro-rotation strobe and index
//   dp_x, dp_y                datapath results (sampled in the capture cycle)
//   rsp_valid/ready/id/x/y    result port
//   busy                      high whenever a job is in flight
//   dbg_state                 current FSM state, for checkers and debug
// -----------------------------------------------------------------------------
module cordic_sequencer #(
  parameter int ITERATIONS = 16,
  parameter int IDX_W      = 4,
  parameter int WIDTH      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_angle,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_angle,
  output logic             req1_ready,
  output logic             dp_load,
  output logic [WIDTH-1:0] dp_angle,
  output logic             dp_en,
  output logic [IDX_W-1:0] dp_iter,
  input  logic [WIDTH-1:0] dp_x,
  input  logic [WIDTH-1:0] dp_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_x,
  output logic [WIDTH-1:0] rsp_y,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ITER = 3'd2,
    S_CAPT = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_ITER = IDX_W'(ITERATIONS - 1);

  state_t state_q;
  state_t state_d;
  logic   last_grant_q;
  logic   grant_id;
  logic   accept;

  assign dbg_state = state_q;

  // Round-robin pick: a lone requester always wins; with both pending the
  // one that was not granted last time goes next.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign accept     = (state_q == S_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && req0_valid && !grant_id;
  assign req1_ready = accept && req1_valid &&  grant_id;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_LOAD;
      S_LOAD: state_d = S_ITER;
      // The index register holds the rotation being performed this cycle,
      // so leaving on the last index never lets it wrap.
      S_ITER: if (dp_iter == LAST_ITER) state_d = S_CAPT;
      S_CAPT: state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus registered outputs. Strobes are decoded from the
  // next state so they line up with the state they belong to while still
  // coming straight out of flops; reset therefore drops them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      dp_load      <= 1'b0;
      dp_en        <= 1'b0;
      dp_iter      <= '0;
      dp_angle     <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_x        <= '0;
      rsp_y        <= '0;
      busy         <= 1'b0;
    end else begin
      state_q   <= state_d;
      dp_load   <= (state_d == S_LOAD);
      dp_en     <= (state_d == S_ITER);
      rsp_valid <= (state_d == S_RESP);
      busy      <= (state_d != S_IDLE);

      // Index counts only across consecutive ITER cycles, zero elsewhere.
      if ((state_q == S_ITER) && (state_d == S_ITER)) begin
        dp_iter <= dp_iter + IDX_W'(1);
      end else begin
        dp_iter <= '0;
      end

      if (accept) begin
        dp_angle     <= grant_id ? req1_angle : req0_angle;
        rsp_id       <= grant_id;
        last_grant_q <= grant_id;
      end

      // Datapath outputs are final one cycle after the last rotation.
      if (state_q == S_CAPT) begin
        rsp_x <= dp_x;
        rsp_y <= dp_y;
      end
    end
  end

endmodule

// File: tb/tb_cordic_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cordic_sequencer
//
// Cycle-level bench: random requesters and datapath values are driven each
// cycle; a job-timeline model (cycles elapsed since acceptance) predicts every
// strobe, the arbitration result and the response, and a queue holds expected
// responses captured at the capture cycle.
// -----------------------------------------------------------------------------
module tb_cordic_sequencer;
  localparam int ITER = 16;
  localparam int IW   = 4;
  localparam int W    = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_angle, req1_angle;
  logic          dp_load, dp_en;
  logic [W-1:0]  dp_angle, dp_x, dp_y;
  logic [IW-1:0] dp_iter;
  logic          rsp_valid, rsp_ready, rsp_id, busy;
  logic [W-1:0]  rsp_x, rsp_y;
  logic [2:0]    dbg_state;

  cordic_sequencer #(.ITERATIONS(ITER), .IDX_W(IW), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_angle(req0_angle), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_angle(req1_angle), .req1_ready(req1_ready),
    .dp_load(dp_load), .dp_angle(dp_angle), .dp_en(dp_en), .dp_iter(dp_iter),
    .dp_x(dp_x), .dp_y(dp_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .busy(busy), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: job timeline
  bit             m_active;
  int             m_age;       // cycles since the accepting edge
  bit             m_last_g;
  logic [W-1:0]   m_angle;
  bit             m_id;
  logic [2*W:0]   exp_q[$];    // {id, x, y} awaiting delivery
  int             grant_log[$];
  int             cyc, acc_cyc;
  bit             prev_rv;

  // stimulus controls
  int rate0, rate1, rsp_rate;
  bit stall_mode;
  bit drop0, drop1;

  task automatic model_reset();
    m_active = 0;
    m_age    = 0;
    m_last_g = 1;
    m_angle  = '0;
    exp_q.delete();
    prev_rv  = 0;
  endtask

  // One clock cycle; entered and left just after a falling edge.
  task automatic step();
    bit e0, e1, win;
    logic exp_en, exp_rv;
    logic [2*W:0] ent;
    exp_en = m_active && (m_age >= 2) && (m_age <= ITER + 1);
    exp_rv = m_active && (m_age >= ITER + 3);
    check_eq("dp_load", dp_load, m_active && (m_age == 1));
    check_eq("dp_en", dp_en, exp_en);
    check_eq("dp_iter", dp_iter, exp_en ? m_age - 2 : 0);
    check_eq("busy", busy, m_active);
    check_eq("rsp_valid", rsp_valid, exp_rv);
    check_eq("dp_angle", dp_angle, m_angle);
    if (exp_rv && exp_q.size() > 0) begin
      ent = exp_q[0];
      check_eq("rsp_id", rsp_id, ent[2*W]);
      check_eq("rsp_x", rsp_x, ent[2*W-1:W]);
      check_eq("rsp_y", rsp_y, ent[W-1:0]);
    end
    if (rsp_valid && !prev_rv) check_eq("latency", cyc - acc_cyc, ITER + 3);
    prev_rv = rsp_valid;
    check_eq("load_en_excl", dp_load & dp_en, 0);
    check_eq("iter_range", dp_iter < ITER, 1);

    // driver
    if (drop0) begin req0_valid = 0; drop0 = 0; end
    if (drop1) begin req1_valid = 0; drop1 = 0; end
    if (!req0_valid && ($urandom_range(99) < rate0)) begin req0_valid = 1; req0_angle = W'($urandom); end
    if (!req1_valid && ($urandom_range(99) < rate1)) begin req1_valid = 1; req1_angle = W'($urandom); end
    rsp_ready = stall_mode ? (m_age >= ITER + 13) : ($urandom_range(99) < rsp_rate);
    dp_x = W'($urandom);
    dp_y = W'($urandom);
    #1;

    e0 = 0; e1 = 0;
    if (!m_active && (req0_valid || req1_valid)) begin
      if (req0_valid && req1_valid) win = !m_last_g;
      else win = req1_valid;
      e0 = !win;
      e1 = win;
    end
    check_eq("req0_ready", req0_ready, e0);
    check_eq("req1_ready", req1_ready, e1);
    check_eq("ready_excl", req0_ready & req1_ready, 0);

    // model advance for the coming rising edge
    if (m_active) begin
      if (m_age == ITER + 2) exp_q.push_back({m_id, dp_x, dp_y});
      if ((m_age >= ITER + 3) && rsp_ready) begin
        m_active = 0;
        void'(exp_q.pop_front());
      end else begin
        m_age++;
      end
    end else if (e0 || e1) begin
      m_active = 1;
      m_age    = 1;
      m_id     = e1;
      m_last_g = e1;
      m_angle  = e1 ? req1_angle : req0_angle;
      acc_cyc  = cyc;
      grant_log.push_back(int'(e1));
      drop0 = e0;
      drop1 = e1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    rate0 = 0; rate1 = 0; rsp_rate = 100; stall_mode = 0;
    n = 0;
    while ((m_active || req0_valid || req1_valid) && n < 300) begin
      step();
      n++;
    end
    check_eq("drain_done", busy | (n >= 300), 0);
  endtask

  initial begin
    rst = 1;
    req0_valid = 0; req1_valid = 0; req0_angle = '0; req1_angle = '0;
    dp_x = '0; dp_y = '0; rsp_ready = 0;
    rate0 = 0; rate1 = 0; rsp_rate = 100; stall_mode = 0; drop0 = 0; drop1 = 0;
    cyc = 0; acc_cyc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_dp_load", dp_load, 0);
    check_eq("rst_dp_en", dp_en, 0);
    check_eq("rst_dp_iter", dp_iter, 0);
    check_eq("rst_dp_angle", dp_angle, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_id", rsp_id, 0);
    check_eq("rst_rsp_x", rsp_x, 0);
    check_eq("rst_rsp_y", rsp_y, 0);
    check_eq("rst_busy", busy, 0);
    rst = 0;
    @(negedge clk);

    // both requesters pending from reset: grants alternate starting with 0
    rate0 = 100; rate1 = 100; rsp_rate = 100;
    repeat (4 * (ITER + 4) + 2) step();
    check_eq("grant_count", grant_log.size() >= 4, 1);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) check_eq("grant_order", grant_log[i], i % 2);
    drain();

    // single requester, fixed angle
    req0_valid = 1; req0_angle = 16'h2000;
    drain();

    // response held off for 10 cycles with both requesters waiting
    rate0 = 100; rate1 = 100; stall_mode = 1;
    repeat (2 * (ITER + 14) + 2) step();
    drain();

    // req1 arrives while a req0 job is iterating
    req0_valid = 1; req0_angle = W'($urandom);
    for (int i = 0; i < 10 && !(m_active && m_age == 5); i++) step();
    req1_valid = 1; req1_angle = W'($urandom);
    drain();

    // asynchronous reset in the middle of iteration 7
    req0_valid = 1; req0_angle = W'($urandom);
    for (int i = 0; i < 20 && !(m_active && m_age == 9); i++) step();
    check_eq("pre_rst_iter", dp_iter, 7);
    check_eq("pre_rst_en", dp_en, 1);
    #2 rst = 1;
    #1;
    check_eq("mid_rst_en", dp_en, 0);
    check_eq("mid_rst_load", dp_load, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_rsp_valid", rsp_valid, 0);
    check_eq("mid_rst_iter", dp_iter, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    req0_valid = 1; req0_angle = W'($urandom);
    drain();

    // random traffic
    for (int blk = 0; blk < 15; blk++) begin
      rate0 = $urandom_range(90, 5);
      rate1 = $urandom_range(90, 5);
      rsp_rate = $urandom_range(90, 30);
      repeat (100) step();
    end
    drain();
    check_eq("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
